// File: rtl/plic_claim_sequencer_if.sv
// ---------------------------------------------------------------------------
// plic_claim_sequencer_if
//
// Purpose: groups all non-clock/reset signals of the PLIC claim sequencer
// into one bundle. The "master" side is the hart/bus agent that drives
// sources, configuration, claims and completions. The "slave" side is the
// sequencer itself.
//
// Signals (widths follow N_SRC / PRIO_W, ID_W = clog2(N_SRC+1)):
//   src            [N_SRC]         synchronized interrupt lines, bit i-1 = ID i
//   prio           [N_SRC*PRIO_W]  flat per-source priority, slice i-1 = ID i
//   enable         [N_SRC]         per-source enable for this target
//   threshold      [PRIO_W]        target priority threshold
//   irq            [1]             interrupt request to the hart
//   claim_req      [1]             single-cycle claim pulse
//   claim_ack      [1]             claim response valid
//   claim_id       [ID_W]          claimed source ID (0 = none)
//   complete_valid [1]             completion pulse
//   complete_id    [ID_W]          ID being completed
//   pending        [N_SRC]         gateway pending bits
// ---------------------------------------------------------------------------
interface plic_claim_sequencer_if #(
  parameter int N_SRC  = 8,
  parameter int PRIO_W = 3
);
  localparam int ID_W = $clog2(N_SRC + 1);

  logic [N_SRC-1:0]        src;
  logic [N_SRC*PRIO_W-1:0] prio;
  logic [N_SRC-1:0]        enable;
  logic [PRIO_W-1:0]       threshold;
  logic                    irq;
  logic                    claim_req;
  logic                    claim_ack;
  logic [ID_W-1:0]         claim_id;
  logic                    complete_valid;
  logic [ID_W-1:0]         complete_id;
  logic [N_SRC-1:0]        pending;

  modport master (
    output src, prio, enable, threshold, claim_req, complete_valid, complete_id,
    input  irq, claim_ack, claim_id, pending
  );

  modport slave (
    input  src, prio, enable, threshold, claim_req, complete_valid, complete_id,
    output irq, claim_ack, claim_id, pending
  );
endinterface

// File: rtl/plic_claim_sequencer.sv
// ---------------------------------------------------------------------------
// plic_claim_sequencer
//
// Purpose: single-target PLIC core. Per-source gateways latch requests into
// pending bits; a sequential scanner visits one source per cycle (IDs
// 1..N_SRC) looking for the highest-priority enabled pending source, then
// spends one UPDATE cycle publishing the result. irq is raised when the
// published priority exceeds the threshold. A claim returns the published
// ID, moves it from pending to inflight and restarts the sweep; a completion
// clears the inflight bit so the gateway can accept the source again.
//
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-low reset
//   bus    plic_claim_sequencer_if.slave (src, prio, enable, threshold,
//          irq, claim_req/claim_ack/claim_id, complete_valid/complete_id,
//          pending)
//
// Configuration macro:
//   PLIC_SEQ_EDGE_GW_EN  defined   -> edge-triggered gateways (0->1 on src)
//                        undefined -> level-triggered gateways
// ---------------------------------------------------------------------------
module plic_claim_sequencer #(
  parameter int N_SRC  = 8,
  parameter int PRIO_W = 3
) (
  input logic                   clock,
  input logic                   reset,
  plic_claim_sequencer_if.slave bus
);
  localparam int ID_W = $clog2(N_SRC + 1);

  typedef enum logic {
    SCAN   = 1'b0,
    UPDATE = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   scan_idx, scan_idx_nxt;
  logic [ID_W-1:0]   run_id, run_id_nxt;
  logic [PRIO_W-1:0] run_prio, run_prio_nxt;
  logic [ID_W-1:0]   best_id, best_id_nxt;
  logic [PRIO_W-1:0] best_prio, best_prio_nxt;
  logic              irq_q, irq_nxt;
  logic              claim_ack_q, claim_ack_nxt;
  logic [ID_W-1:0]   claim_id_q, claim_id_nxt;
  logic [N_SRC-1:0]  pending_q, pending_nxt;
  logic [N_SRC-1:0]  inflight_q, inflight_nxt;

  logic [N_SRC-1:0]  gw_set;
  logic [N_SRC-1:0]  claim_mask;
  logic [N_SRC-1:0]  complete_mask;
  logic [ID_W-1:0]   claim_sel;
  logic              cur_pend;
  logic              cur_en;
  logic [PRIO_W-1:0] cur_prio;

  // -------------------------------------------------------------------------
  // Gateways
  // -------------------------------------------------------------------------
`ifdef PLIC_SEQ_EDGE_GW_EN
  logic [N_SRC-1:0] src_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) src_q <= '0;
    else        src_q <= bus.src;
  end

  // Rising edges seen while pending or inflight are dropped, not counted.
  assign gw_set = bus.src & ~src_q & ~inflight_q & ~pending_q;
`else
  assign gw_set = bus.src & ~inflight_q & ~pending_q;
`endif

  // -------------------------------------------------------------------------
  // Claim / complete decode
  // -------------------------------------------------------------------------
  // A claim only returns a real ID while irq is asserted; otherwise ID 0.
  assign claim_sel = irq_q ? best_id : '0;

  always_comb begin
    claim_mask    = '0;
    complete_mask = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (bus.claim_req && (claim_sel == ID_W'(i + 1)))
        claim_mask[i] = 1'b1;
      // Out-of-range IDs (0, > N_SRC) never match, so they are ignored here.
      if (bus.complete_valid && (bus.complete_id == ID_W'(i + 1)) && inflight_q[i])
        complete_mask[i] = 1'b1;
    end
  end

  // Claim set wins over a same-cycle completion of the same ID.
  assign pending_nxt  = (pending_q | gw_set) & ~claim_mask;
  assign inflight_nxt = (inflight_q & ~complete_mask) | claim_mask;

  assign claim_ack_nxt = bus.claim_req;
  assign claim_id_nxt  = bus.claim_req ? claim_sel : '0;

  // -------------------------------------------------------------------------
  // Scanner: select the source currently being visited
  // -------------------------------------------------------------------------
  always_comb begin
    cur_pend = 1'b0;
    cur_en   = 1'b0;
    cur_prio = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (scan_idx == ID_W'(i + 1)) begin
        cur_pend = pending_q[i];
        cur_en   = bus.enable[i];
        cur_prio = bus.prio[i*PRIO_W +: PRIO_W];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Scanner FSM next-state
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt     = state;
    scan_idx_nxt  = scan_idx;
    run_id_nxt    = run_id;
    run_prio_nxt  = run_prio;
    best_id_nxt   = best_id;
    best_prio_nxt = best_prio;
    irq_nxt       = irq_q;

    if (bus.claim_req) begin
      // Any claim invalidates the published result and restarts the sweep.
      state_nxt     = SCAN;
      scan_idx_nxt  = ID_W'(1);
      run_id_nxt    = '0;
      run_prio_nxt  = '0;
      best_id_nxt   = '0;
      best_prio_nxt = '0;
      irq_nxt       = 1'b0;
    end else begin
      case (state)
        SCAN: begin
          // Strictly-greater compare keeps the lowest ID on ties; since the
          // running best starts at 0, priority-0 sources never qualify.
          if (cur_pend && cur_en && (cur_prio > run_prio)) begin
            run_id_nxt   = scan_idx;
            run_prio_nxt = cur_prio;
          end
          if (scan_idx == ID_W'(N_SRC))
            state_nxt = UPDATE;
          else
            scan_idx_nxt = scan_idx + ID_W'(1);
        end
        UPDATE: begin
          best_id_nxt   = run_id;
          best_prio_nxt = run_prio;
          irq_nxt       = (run_prio > bus.threshold);
          run_id_nxt    = '0;
          run_prio_nxt  = '0;
          scan_idx_nxt  = ID_W'(1);
          state_nxt     = SCAN;
        end
        default: begin
          state_nxt    = SCAN;
          scan_idx_nxt = ID_W'(1);
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= SCAN;
      scan_idx    <= ID_W'(1);
      run_id      <= '0;
      run_prio    <= '0;
      best_id     <= '0;
      best_prio   <= '0;
      irq_q       <= 1'b0;
      claim_ack_q <= 1'b0;
      claim_id_q  <= '0;
      pending_q   <= '0;
      inflight_q  <= '0;
    end else begin
      state       <= state_nxt;
      scan_idx    <= scan_idx_nxt;
      run_id      <= run_id_nxt;
      run_prio    <= run_prio_nxt;
      best_id     <= best_id_nxt;
      best_prio   <= best_prio_nxt;
      irq_q       <= irq_nxt;
      claim_ack_q <= claim_ack_nxt;
      claim_id_q  <= claim_id_nxt;
      pending_q   <= pending_nxt;
      inflight_q  <= inflight_nxt;
    end
  end

  assign bus.irq       = irq_q;
  assign bus.claim_ack = claim_ack_q;
  assign bus.claim_id  = claim_id_q;
  assign bus.pending   = pending_q;

endmodule

// File: tb/tb_plic_claim_sequencer.sv
`timescale 1ns/1ps
module tb_plic_claim_sequencer;
  localparam int N_SRC  = 8;
  localparam int PRIO_W = 3;
  localparam int ID_W   = $clog2(N_SRC + 1);

  logic clock;
  logic reset;
  int   passed = 0;
  int   total  = 0;

  plic_claim_sequencer_if #(.N_SRC(N_SRC), .PRIO_W(PRIO_W)) bus ();

  plic_claim_sequencer #(.N_SRC(N_SRC), .PRIO_W(PRIO_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers (no checking inside) ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.src            = '0;
    bus.prio           = '0;
    bus.enable         = '0;
    bus.threshold      = '0;
    bus.claim_req      = 1'b0;
    bus.complete_valid = 1'b0;
    bus.complete_id    = '0;
  endtask

  task automatic set_prio(input int id, input int p);
    bus.prio[(id-1)*PRIO_W +: PRIO_W] = PRIO_W'(p);
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    step(2);
    reset = 1'b1;
  endtask

  task automatic wait_irq(input int max, output int n);
    n = 0;
    while (bus.irq !== 1'b1 && n < max) begin
      step(1);
      n++;
    end
  endtask

  task automatic claim();
    bus.claim_req = 1'b1;
    step(1);
    bus.claim_req = 1'b0;
  endtask

  task automatic complete(input int id);
    bus.complete_valid = 1'b1;
    bus.complete_id    = ID_W'(id);
    step(1);
    bus.complete_valid = 1'b0;
    bus.complete_id    = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    bus.src = '1;
    step(2);
    total++; if (bus.irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", bus.irq); else passed++;
    total++; if (bus.claim_ack !== 1'b0) $display("FAIL reset_claim_ack: got %b expected 0", bus.claim_ack); else passed++;
    total++; if (bus.claim_id !== 4'd0) $display("FAIL reset_claim_id: got %0d expected 0", bus.claim_id); else passed++;
    total++; if (bus.pending !== 8'h00) $display("FAIL reset_pending: got %h expected 00", bus.pending); else passed++;
    bus.src = '0;
  endtask

  task automatic test_tie_break();
    int n;
    idle_inputs();
    bus.enable = '1;
    set_prio(3, 2);
    set_prio(5, 2);
    bus.src = 8'b0001_0100;
    reset_pulse();
    wait_irq(9, n);
    total++; if (bus.irq !== 1'b1) $display("FAIL tie_irq_within_9: got %b after %0d cycles expected 1", bus.irq, n); else passed++;
    total++; if (bus.pending !== 8'h14) $display("FAIL tie_pending: got %h expected 14", bus.pending); else passed++;
    claim();
    total++; if (bus.claim_ack !== 1'b1) $display("FAIL tie_claim_ack: got %b expected 1", bus.claim_ack); else passed++;
    total++; if (bus.claim_id !== 4'd3) $display("FAIL tie_claim_id_first: got %0d expected 3", bus.claim_id); else passed++;
    total++; if (bus.pending !== 8'h10) $display("FAIL tie_pending_after_claim: got %h expected 10", bus.pending); else passed++;
    wait_irq(10, n);
    total++; if (bus.irq !== 1'b1) $display("FAIL tie_irq_second: got %b expected 1", bus.irq); else passed++;
    claim();
    total++; if (bus.claim_id !== 4'd5) $display("FAIL tie_claim_id_second: got %0d expected 5", bus.claim_id); else passed++;
    // Back-to-back claim while claim_ack is high: irq was cleared, so ID 0.
    claim();
    total++; if (bus.claim_ack !== 1'b1) $display("FAIL b2b_claim_ack: got %b expected 1", bus.claim_ack); else passed++;
    total++; if (bus.claim_id !== 4'd0) $display("FAIL b2b_claim_id: got %0d expected 0", bus.claim_id); else passed++;
    bus.src = '0;
    complete(3);
    complete(5);
    step(1);
    total++; if (bus.pending !== 8'h00) $display("FAIL tie_pending_cleanup: got %h expected 00", bus.pending); else passed++;
  endtask

  task automatic test_threshold();
    int n;
    int bad;
    idle_inputs();
    bus.enable    = '1;
    bus.threshold = 3'd4;
    set_prio(2, 4);
    bus.src = 8'b0000_0010;
    reset_pulse();
    bad = 0;
    repeat (20) begin
      step(1);
      if (bus.irq !== 1'b0) bad++;
    end
    total++; if (bad !== 0) $display("FAIL thr_equal_no_irq: irq high in %0d cycles expected 0", bad); else passed++;
    set_prio(2, 5);
    wait_irq(18, n);
    total++; if (bus.irq !== 1'b1) $display("FAIL thr_raise_irq: got %b expected 1", bus.irq); else passed++;
    claim();
    total++; if (bus.claim_id !== 4'd2) $display("FAIL thr_claim_id: got %0d expected 2", bus.claim_id); else passed++;
    bus.src = '0;
    complete(2);
  endtask

`ifndef PLIC_SEQ_EDGE_GW_EN
  task automatic test_level_gateway();
    int n;
    idle_inputs();
    bus.enable = '1;
    set_prio(6, 1);
    bus.src = 8'b0010_0000;
    reset_pulse();
    wait_irq(10, n);
    claim();
    total++; if (bus.claim_id !== 4'd6) $display("FAIL lvl_claim_id: got %0d expected 6", bus.claim_id); else passed++;
    step(3);
    total++; if (bus.pending[5] !== 1'b0) $display("FAIL lvl_pending_inflight: got %b expected 0", bus.pending[5]); else passed++;
    complete(6);
    step(1);
    total++; if (bus.pending[5] !== 1'b1) $display("FAIL lvl_pending_reassert: got %b expected 1", bus.pending[5]); else passed++;
    wait_irq(18, n);
    total++; if (bus.irq !== 1'b1) $display("FAIL lvl_irq_reassert: got %b expected 1", bus.irq); else passed++;
    bus.src = '0;
    claim();
    complete(6);
  endtask
`endif

`ifdef PLIC_SEQ_EDGE_GW_EN
  task automatic test_edge_gateway();
    int n;
    idle_inputs();
    bus.enable = '1;
    set_prio(2, 1);
    reset_pulse();
    bus.src[1] = 1'b1;
    step(1);
    bus.src[1] = 1'b0;
    wait_irq(20, n);
    claim();
    total++; if (bus.claim_id !== 4'd2) $display("FAIL edge_claim_id: got %0d expected 2", bus.claim_id); else passed++;
    bus.src[1] = 1'b1;
    step(1);
    bus.src[1] = 1'b0;
    step(3);
    total++; if (bus.pending[1] !== 1'b0) $display("FAIL edge_drop_inflight: got %b expected 0", bus.pending[1]); else passed++;
    complete(2);
    bus.src[1] = 1'b1;
    step(1);
    bus.src[1] = 1'b0;
    step(1);
    total++; if (bus.pending[1] !== 1'b1) $display("FAIL edge_after_complete: got %b expected 1", bus.pending[1]); else passed++;
  endtask
`endif

  task automatic test_errors();
    int n;
    idle_inputs();
    bus.enable = '1;
    set_prio(1, 1);
    reset_pulse();
    claim();
    total++; if (bus.claim_ack !== 1'b1) $display("FAIL err_noirq_ack: got %b expected 1", bus.claim_ack); else passed++;
    total++; if (bus.claim_id !== 4'd0) $display("FAIL err_noirq_id: got %0d expected 0", bus.claim_id); else passed++;
    step(1);
    total++; if (bus.claim_ack !== 1'b0) $display("FAIL err_ack_drop: got %b expected 0", bus.claim_ack); else passed++;
    bus.src[0] = 1'b1;
    wait_irq(20, n);
    claim();
    total++; if (bus.claim_id !== 4'd1) $display("FAIL err_claim_id: got %0d expected 1", bus.claim_id); else passed++;
    bus.src[0] = 1'b0;
    step(1);
    bus.src[0] = 1'b1;
    complete(0);
    complete(9);
    complete(2);
    step(2);
    total++; if (bus.pending !== 8'h00) $display("FAIL err_bad_complete: got %h expected 00", bus.pending); else passed++;
    complete(1);
    bus.src[0] = 1'b0;
    step(1);
    bus.src[0] = 1'b1;
    step(2);
    total++; if (bus.pending[0] !== 1'b1) $display("FAIL err_good_complete: got %b expected 1", bus.pending[0]); else passed++;
    bus.src = '0;
  endtask

  task automatic test_same_cycle();
    int n;
    idle_inputs();
    bus.enable = '1;
    set_prio(4, 3);
    set_prio(1, 1);
    bus.src = 8'b0000_1000;
    reset_pulse();
    wait_irq(10, n);
    claim();
    total++; if (bus.claim_id !== 4'd4) $display("FAIL same_setup_id: got %0d expected 4", bus.claim_id); else passed++;
    bus.src = 8'b0000_0001;
    wait_irq(20, n);
    bus.claim_req      = 1'b1;
    bus.complete_valid = 1'b1;
    bus.complete_id    = 4'd4;
    step(1);
    bus.claim_req      = 1'b0;
    bus.complete_valid = 1'b0;
    bus.complete_id    = '0;
    total++; if (bus.claim_ack !== 1'b1) $display("FAIL same_claim_ack: got %b expected 1", bus.claim_ack); else passed++;
    total++; if (bus.claim_id !== 4'd1) $display("FAIL same_claim_id: got %0d expected 1", bus.claim_id); else passed++;
    bus.src = 8'b0100_1001;
    step(2);
    total++; if (bus.pending[3] !== 1'b1) $display("FAIL same_inflight4_cleared: got %b expected 1", bus.pending[3]); else passed++;
    total++; if (bus.pending[6] !== 1'b1) $display("FAIL same_prio0_pends: got %b expected 1", bus.pending[6]); else passed++;
    wait_irq(20, n);
    claim();
    total++; if (bus.claim_id !== 4'd4) $display("FAIL async_pre_id: got %0d expected 4", bus.claim_id); else passed++;
    #2 reset = 1'b0;
    #1;
    total++; if (bus.claim_ack !== 1'b0) $display("FAIL async_claim_ack: got %b expected 0", bus.claim_ack); else passed++;
    total++; if (bus.claim_id !== 4'd0) $display("FAIL async_claim_id: got %0d expected 0", bus.claim_id); else passed++;
    total++; if (bus.pending !== 8'h00) $display("FAIL async_pending: got %h expected 00", bus.pending); else passed++;
    reset = 1'b1;
    wait_irq(20, n);
    total++; if (bus.irq !== 1'b1) $display("FAIL async_pre_irq: got %b expected 1", bus.irq); else passed++;
    #2 reset = 1'b0;
    #1;
    total++; if (bus.irq !== 1'b0) $display("FAIL async_irq: got %b expected 0", bus.irq); else passed++;
    bus.claim_req = 1'b1;
    step(1);
    bus.claim_req = 1'b0;
    reset = 1'b1;
    step(2);
    total++; if (bus.claim_ack !== 1'b0) $display("FAIL reset_claim_discard: got %b expected 0", bus.claim_ack); else passed++;
    bus.src = '0;
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    test_reset();
    test_tie_break();
    test_threshold();
`ifndef PLIC_SEQ_EDGE_GW_EN
    test_level_gateway();
`else
    test_edge_gateway();
`endif
    test_errors();
    test_same_cycle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/plic_claim_sequencer.md
PLIC_CLAIM_SEQUENCER -- requirements
Module: plic_claim_sequencer

Interface
REQ-001 Parameter N_SRC, default 8: number of interrupt sources, with IDs 1..N_SRC; ID 0 means "no interrupt".
REQ-002 Parameter PRIO_W, default 3: priority width; priority 0 never interrupts.
REQ-003 Derived ID_W = clog2(N_SRC+1).
REQ-004 clock  input  1  single clock; all state is on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 src  input  N_SRC  interrupt lines, already synchronized; bit i-1 is source ID i.
REQ-007 prio  input  N_SRC*PRIO_W  per-source priority, flat; slice i-1 is ID i.
REQ-008 enable  input  N_SRC  per-source enable for this target.
REQ-009 threshold  input  PRIO_W  target priority threshold.
REQ-010 irq  output  1  interrupt request to the hart.
REQ-011 claim_req  input  1  single-cycle claim pulse.
REQ-012 claim_ack  output  1  claim response valid.
REQ-013 claim_id  output  ID_W  claimed source ID.
REQ-014 complete_valid  input  1  completion pulse.
REQ-015 complete_id  input  ID_W  ID being completed.
REQ-016 pending  output  N_SRC  gateway pending bits.

Function
REQ-017 Gateway: pending[i] SHALL set when the source is asserted and inflight[i]=0 and pending[i]=0.
REQ-018 Scanner FSM, states SCAN and UPDATE:
- SCAN visits one source per cycle, IDs 1..N_SRC in order.
- A candidate is a source with pending & enable & prio>0.
- Running best is replaced only on strictly greater priority, so the lowest ID wins ties.
REQ-019 SCAN -> UPDATE after ID N_SRC is visited; UPDATE latches best_id/best_prio, clears the running best, and returns to SCAN at ID 1. A full sweep takes N_SRC+1 cycles.
REQ-020 irq SHALL be registered as (best_prio > threshold) and be valid from the cycle after UPDATE.
REQ-021 Claim: claim_req in cycle T SHALL produce:
- claim_ack=1 in T+1.
- claim_id = best_id if irq=1 in T, else 0.
- If the ID is nonzero: clear pending[id] and set inflight[id] in T+1.
REQ-022 Any claim SHALL abort the current sweep:
- Clear best_id, best_prio and irq in T+1.
- Restart SCAN at ID 1.
REQ-023 Complete: complete_valid with 1 <= complete_id <= N_SRC and inflight set SHALL clear inflight in the next cycle; otherwise the completion is silently ignored.
REQ-024 Claim and complete in the same cycle SHALL both take effect. Completing the just-claimed ID in that same cycle does not clear its new inflight bit.
REQ-025 Changes to prio, enable or threshold SHALL take effect no later than the end of the next full sweep.
REQ-026 claim_req while claim_ack=1 SHALL be accepted as a new claim; back-to-back claims are legal.

Reset
REQ-027 While reset=0, all state SHALL clear asynchronously: pending, inflight, best_id, best_prio, irq, claim_ack, claim_id. The FSM goes to SCAN at ID 1.
REQ-028 Reset in the middle of a claim or sweep SHALL discard the operation; no claim_ack is issued after reset release.

Configuration
REQ-029 Macro PLIC_SEQ_EDGE_GW_EN selects the gateway type.
- Defined: edge-triggered gateways. pending[i] sets on a 0->1 transition of src[i] (one register per source) while inflight[i]=0. Edges during inflight or pending are dropped, not counted.
- Undefined: level-triggered gateways per REQ-017, with no edge registers.

Verification
REQ-030 Setup N_SRC=8, threshold=0. Source 3 prio 2 and source 5 prio 2 pending and enabled.
- Expected: irq=1 within 9 cycles; claim_id=3 on claim.
- Then: claim again -> claim_id=5.
REQ-031 Setup threshold=4, source 2 prio 4. Expected: irq stays 0.
- Then: raise prio to 5 -> irq=1 within 18 cycles; claim -> id 2.
REQ-032 Level mode: source 6 held high. Claim returns 6, and pending[6] stays 0 while inflight.
- Then: complete_id=6 -> pending[6] reasserts the next cycle; irq reasserts after a sweep.
REQ-033 Error and boundary cases:
- complete_id=0, complete_id=9, or completing a non-inflight ID -> no state change.
- Claim with irq=0 -> claim_ack=1 and claim_id=0.
REQ-034 Same-cycle events: claim_req and complete_valid(id=4, inflight) together -> claim handled and inflight[4] cleared in the same cycle.
- Then: assert reset mid-sweep -> all outputs 0 asynchronously.
REQ-035 With PLIC_SEQ_EDGE_GW_EN defined, a pulse on src[1] during inflight[1] is dropped.
- Then: a pulse after completion -> pending[1]=1.
